decode_queue: RTL

- Parametrised instruction-decode stage with buffering, placed between fetch and the ID/EX pipeline register of RVS192.
- Accepts raw instructions and their PC over a valid/ready handshake and decodes each one combinationally as it is pushed.
- Stores the decoded entries in a DEPTH-entry FIFO and presents the head entry to execute over a second valid/ready handshake.
- Adds illegal-instruction detection, an optional RV32M decode, flush support and occupancy reporting.

---
 rtl/decode_queue_pkg.sv | 67 ++++++
 rtl/decode_queue_inst_decode.sv | 175 +++++++++++++++++
 rtl/decode_queue.sv | 95 +++++++++
 3 files changed

// File: rtl/decode_queue_pkg.sv
// Shared decode types for the RVS192 decode queue: ALU/branch/memory enums,
// the execute-stage control bundle and the buffered entry format.
package decode_queue_pkg;

    localparam int INST_LENGTH = 32;
    localparam int XLEN        = 32;
    // Widest PC an entry can carry; decode_queue PC_W must not exceed it.
    localparam int PC_MAX_W    = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_B_TYPE = 7'b1100011;
    localparam logic [6:0] OPC_L_TYPE = 7'b0000011;
    localparam logic [6:0] OPC_S_TYPE = 7'b0100011;
    localparam logic [6:0] OPC_I_TYPE = 7'b0010011;
    localparam logic [6:0] OPC_R_TYPE = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [1:0] IN1_RS1  = 2'd0;
    localparam logic [1:0] IN1_PC   = 2'd1;
    localparam logic [1:0] IN1_ZERO = 2'd2;

    localparam logic [1:0] WB_ALU    = 2'd0;
    localparam logic [1:0] WB_MULDIV = 2'd1;
    localparam logic [1:0] WB_MEM    = 2'd2;
    localparam logic [1:0] WB_LINK   = 2'd3;

    typedef enum logic [4:0] {
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, SC, USC,
        MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
    } alu_op_e;

    typedef enum logic [2:0] {NO_BRANCH, EQUAL, N_EQUAL, LT, GE} branch_kind_e;

    typedef enum logic [2:0] {BYTE, HALF, WORD, BYTE_U, HALF_U} mem_gen_e;

    typedef struct packed {
        alu_op_e            alu_op;
        logic [1:0]         alu_in1_sel;
        logic               alu_in2_sel;
        logic [XLEN-1:0]    imm_dec;
        logic               reg_wen;
        logic [1:0]         wb_sel;
        logic               cpu_read;
        logic               cpu_write;
        mem_gen_e           mem_gen;
        branch_kind_e       branch_kind;
        logic               branch_capture;
        logic               jal;
        logic               jalr;
    } control_type_ex;

    typedef struct packed {
        control_type_ex     ctrl;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic [PC_MAX_W-1:0] pc;
        logic               illegal;
    } decode_entry_t;

endpackage

// File: rtl/decode_queue_inst_decode.sv
// Combinational RV32I (+ optional RV32M) decoder producing execute control,
// register indices and an illegal-instruction flag.
module inst_decode
    import decode_queue_pkg::*;
#(
    parameter int ENABLE_M = 0
) (
    input  logic [INST_LENGTH-1:0] inst,
    output control_type_ex         ctrl,
    output logic [4:0]             rs1,
    output logic [4:0]             rs2,
    output logic [4:0]             rd,
    output logic                   illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic signed [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    control_type_ex c;
    logic bad;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign rd     = inst[11:7];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'd0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        c   = '0;
        bad = 1'b0;
        case (opcode)
            OPC_LUI: begin
                c.alu_in1_sel = IN1_ZERO;
                c.alu_in2_sel = 1'b1;
                c.imm_dec     = imm_u;
                c.reg_wen     = 1'b1;
            end
            OPC_AUIPC: begin
                c.alu_in1_sel = IN1_PC;
                c.alu_in2_sel = 1'b1;
                c.imm_dec     = imm_u;
                c.reg_wen     = 1'b1;
            end
            OPC_JAL: begin
                c.alu_in1_sel = IN1_PC;
                c.alu_in2_sel = 1'b1;
                c.imm_dec     = imm_j;
                c.reg_wen     = 1'b1;
                c.wb_sel      = WB_LINK;
                c.jal         = 1'b1;
            end
            OPC_JALR: begin
                c.alu_in2_sel = 1'b1;
                c.imm_dec     = imm_i;
                c.reg_wen     = 1'b1;
                c.wb_sel      = WB_LINK;
                c.jalr        = 1'b1;
                bad           = (funct3 != 3'b000);
            end
            OPC_B_TYPE: begin
                c.imm_dec        = imm_b;
                c.branch_capture = 1'b1;
                c.alu_op         = SC;
                case (funct3)
                    3'b000: c.branch_kind = EQUAL;
                    3'b001: c.branch_kind = N_EQUAL;
                    3'b100: c.branch_kind = LT;
                    3'b101: c.branch_kind = GE;
                    3'b110: begin c.branch_kind = LT; c.alu_op = USC; end
                    3'b111: begin c.branch_kind = GE; c.alu_op = USC; end
                    default: bad = 1'b1;
                endcase
            end
            OPC_L_TYPE: begin
                c.alu_in2_sel = 1'b1;
                c.imm_dec     = imm_i;
                c.reg_wen     = 1'b1;
                c.wb_sel      = WB_MEM;
                c.cpu_read    = 1'b1;
                case (funct3)
                    3'b000: c.mem_gen = BYTE;
                    3'b001: c.mem_gen = HALF;
                    3'b010: c.mem_gen = WORD;
                    3'b100: c.mem_gen = BYTE_U;
                    3'b101: c.mem_gen = HALF_U;
                    default: bad = 1'b1;
                endcase
            end
            OPC_S_TYPE: begin
                c.alu_in2_sel = 1'b1;
                c.imm_dec     = imm_s;
                c.cpu_write   = 1'b1;
                case (funct3)
                    3'b000: c.mem_gen = BYTE;
                    3'b001: c.mem_gen = HALF;
                    3'b010: c.mem_gen = WORD;
                    default: bad = 1'b1;
                endcase
            end
            OPC_I_TYPE: begin
                c.alu_in2_sel = 1'b1;
                c.imm_dec     = imm_i;
                c.reg_wen     = 1'b1;
                case (funct3)
                    3'b000: c.alu_op = ADD;
                    3'b010: c.alu_op = SLT;
                    3'b011: c.alu_op = SLTU;
                    3'b100: c.alu_op = XOR;
                    3'b110: c.alu_op = OR;
                    3'b111: c.alu_op = AND;
                    3'b001: begin
                        c.alu_op = SLL;
                        bad      = (funct7 != F7_BASE);
                    end
                    default: begin
                        if (funct7 == F7_ALT) c.alu_op = SRA;
                        else                  c.alu_op = SRL;
                        bad = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                    end
                endcase
            end
            OPC_R_TYPE: begin
                c.reg_wen = 1'b1;
                case (funct7)
                    F7_BASE: begin
                        case (funct3)
                            3'b000: c.alu_op = ADD;
                            3'b001: c.alu_op = SLL;
                            3'b010: c.alu_op = SLT;
                            3'b011: c.alu_op = SLTU;
                            3'b100: c.alu_op = XOR;
                            3'b101: c.alu_op = SRL;
                            3'b110: c.alu_op = OR;
                            default: c.alu_op = AND;
                        endcase
                    end
                    F7_ALT: begin
                        if (funct3 == 3'b000)      c.alu_op = SUB;
                        else if (funct3 == 3'b101) c.alu_op = SRA;
                        else                       bad = 1'b1;
                    end
                    F7_MULDIV: begin
                        c.wb_sel = WB_MULDIV;
                        bad      = (ENABLE_M == 0);
                        case (funct3)
                            3'b000: c.alu_op = MUL;
                            3'b001: c.alu_op = MULH;
                            3'b010: c.alu_op = MULHSU;
                            3'b011: c.alu_op = MULHU;
                            3'b100: c.alu_op = DIV;
                            3'b101: c.alu_op = DIVU;
                            3'b110: c.alu_op = REM;
                            default: c.alu_op = REMU;
                        endcase
                    end
                    default: bad = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase
    end

    // An illegal entry carries no side effects and a zero immediate.
    assign ctrl    = bad ? control_type_ex'('0) : c;
    assign illegal = bad;

endmodule

// File: rtl/decode_queue.sv
// Decode stage with a DEPTH-entry FIFO between fetch and the ID/EX register:
// instructions are decoded on push and the head entry is offered to execute.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ENABLE_M = 0,
    parameter int PC_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INST_LENGTH-1:0]       in_inst,
    input  logic [PC_W-1:0]              in_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output control_type_ex               out_ctrl,
    output logic [4:0]                   out_rs1,
    output logic [4:0]                   out_rs2,
    output logic [4:0]                   out_rd,
    output logic [PC_W-1:0]              out_pc,
    output logic                         out_illegal,
    output logic [$clog2(DEPTH+1)-1:0]   out_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop;

    control_type_ex dec_ctrl;
    logic [4:0]     dec_rs1, dec_rs2, dec_rd;
    logic           dec_illegal;
    decode_entry_t  push_entry, head;
    decode_entry_t  mem [DEPTH];

    inst_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .inst    (in_inst),
        .ctrl    (dec_ctrl),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .rd      (dec_rd),
        .illegal (dec_illegal)
    );

    assign in_ready  = (count < CNT_W'(DEPTH)) & ~flush & rst_n;
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready & ~flush;
    assign out_count = count;

    always_comb begin
        push_entry         = '0;
        push_entry.ctrl    = dec_ctrl;
        push_entry.rs1     = dec_rs1;
        push_entry.rs2     = dec_rs2;
        push_entry.rd      = dec_rd;
        push_entry.pc      = PC_MAX_W'(in_pc);
        push_entry.illegal = dec_illegal;
    end

    // Full/empty come from count only; pointers simply wrap.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    // Storage is not reset; outputs are masked to zero whenever the queue is empty.
    assign head        = mem[rd_ptr];
    assign out_ctrl    = out_valid ? head.ctrl : control_type_ex'('0);
    assign out_rs1     = out_valid ? head.rs1 : 5'd0;
    assign out_rs2     = out_valid ? head.rs2 : 5'd0;
    assign out_rd      = out_valid ? head.rd : 5'd0;
    assign out_pc      = out_valid ? head.pc[PC_W-1:0] : '0;
    assign out_illegal = out_valid & head.illegal;

endmodule
